// File: rtl/imem_loader_pkg.sv
// Shared types for the byte-stream instruction loader: FSM states and bus widths.
// Used by the loader top, its stream interface and the bench.
package imem_loader_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_LEN_HI  = 3'd0,
        S_LEN_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_CSUM    = 3'd4,
        S_RUN     = 3'd5,
        S_ERR     = 3'd6
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready byte stream feeding the loader; the source drives valid/data and the loader drives ready.
// A byte transfers on any rising clock edge where in_valid and in_ready are both high.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_data;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/imem_dpram.sv
// Instruction RAM: one synchronous write port, one combinational read port, no reset.
// A word written on edge N is visible on the read port right after that edge.
module imem_dpram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);
    logic [WIDTH-1:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program from a byte stream into instruction RAM, holding the CPU until done.
// One byte per cycle, ready low in RUN/ERR; checksum byte checked when IMEM_LOADER_CSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_if.slave      bus,
    input  logic              reload_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic              oe_i,
    output logic [WORD_W-1:0] data_out_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);
    localparam logic [WORD_W:0] DEPTH = (WORD_W+1)'(1 << DEPTH_LOG2);

`ifdef IMEM_LOADER_CSUM_EN
    localparam state_e AFTER_DATA = S_CSUM;
`else
    localparam state_e AFTER_DATA = S_RUN;
`endif

    state_e                  state_q, state_d;
    logic [WORD_W-1:0]       rem_q, rem_d;
    logic [DEPTH_LOG2-1:0]   waddr_q, waddr_d;
    logic [BYTE_W-1:0]       hi_q, hi_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [BYTE_W-1:0]       csum_q, csum_d;
`endif

    logic                    accept;
    logic                    mem_we;
    logic [WORD_W-1:0]       len;
    logic [WORD_W-1:0]       rdata;
    logic                    rd_ok;

    assign accept = bus.in_valid & bus.in_ready;
    // hi_q holds the length high byte in S_LEN_LO and the word high byte in S_DATA_LO
    assign len    = {hi_q, bus.in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LEN_HI;
            rem_q   <= '0;
            waddr_q <= '0;
            hi_q    <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            waddr_q <= waddr_d;
            hi_q    <= hi_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        waddr_d = waddr_q;
        hi_d    = hi_q;
        mem_we  = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    hi_d    = bus.in_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    if ({1'b0, len} > DEPTH) begin
                        state_d = S_ERR;
                    end else if (len == '0) begin
                        state_d = AFTER_DATA;
                    end else begin
                        rem_d   = len;
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = bus.in_data;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d  = csum_q + bus.in_data;
`endif
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    mem_we  = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d  = csum_q + bus.in_data;
`endif
                    // wraps to 0 after a full-depth load, which is harmless
                    waddr_d = waddr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == 16'd1) ? AFTER_DATA : S_DATA_HI;
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (csum_q == bus.in_data) ? S_RUN : S_ERR;
                end
            end
`endif
            S_RUN, S_ERR: begin
                if (reload_i) begin
                    state_d = S_LEN_HI;
                    rem_d   = '0;
                    waddr_d = '0;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            default: begin
                state_d = S_LEN_HI;
            end
        endcase
    end

    assign bus.in_ready = (state_q != S_RUN) && (state_q != S_ERR);
    assign cpu_hold_o   = (state_q != S_RUN);
    assign done_o       = (state_q == S_RUN);
    assign err_o        = (state_q == S_ERR);

    imem_dpram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WORD_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (waddr_q),
        .wdata_i ({hi_q, bus.in_data}),
        .raddr_i (addr_i[DEPTH_LOG2-1:0]),
        .rdata_o (rdata)
    );

    assign rd_ok      = oe_i & ~cpu_hold_o & ({1'b0, addr_i} < DEPTH);
    assign data_out_o = rd_ok ? rdata : '0;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, gaps, reset mid-load, reload, overflow and (if enabled) bad checksum.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reload;
    logic [15:0] addr;
    logic        oe;
    logic [15:0] data_out;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int nacc  = 0;

    imem_loader_if bus ();

    imem_loader #(.DEPTH_LOG2(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .reload_i   (reload),
        .addr_i     (addr),
        .oe_i       (oe),
        .data_out_o (data_out),
        .cpu_hold_o (cpu_hold),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

`ifdef IMEM_LOADER_CSUM_EN
    localparam int NPROG = 9;
`else
    localparam int NPROG = 8;
`endif
    logic [7:0] prog [9] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; leaves the bench just after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_stall", 32'(n < 20), 32'd1);
        if (n < 20) begin
            @(posedge clk);
            nacc++;
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        chk(tag, 32'(data_out), 32'(exp));
    endtask

    task automatic load_prog(input bit gaps);
        for (int i = 0; i < NPROG; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            send(prog[i]);
            if (i < NPROG - 1) chk("hold_during_load", 32'(cpu_hold), 32'd1);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic check_prog(input string pfx);
        chk({pfx, "_done"},  32'(done), 32'd1);
        chk({pfx, "_hold"},  32'(cpu_hold), 32'd0);
        chk({pfx, "_ready"}, 32'(bus.in_ready), 32'd0);
        read_chk({pfx, "_a0"},   16'd0,   16'h1234);
        read_chk({pfx, "_a1"},   16'd1,   16'hABCD);
        read_chk({pfx, "_a2"},   16'd2,   16'h0001);
        read_chk({pfx, "_a300"}, 16'd300, 16'h0000);
    endtask

    initial begin
        rst          = 1'b1;
        reload       = 1'b0;
        addr         = 16'd0;
        oe           = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        idle(2);
        rst = 1'b0;

        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_hold",  32'(cpu_hold), 32'd1);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        read_chk("rst_dout", 16'd0, 16'h0000);

        // Gapped load: result must match an unstalled load exactly.
        nacc = 0;
        load_prog(1'b1);
        chk("a_bytes", 32'(nacc), 32'(NPROG));
        check_prog("a");
        addr = 16'd1;
        oe   = 1'b0;
        #1;
        chk("a_oe_low", 32'(data_out), 32'd0);
        oe   = 1'b1;
        addr = 16'd0;

        // Reload from RUN re-asserts hold; reload inside a load is ignored.
        pulse_reload();
        chk("rl_hold",  32'(cpu_hold), 32'd1);
        chk("rl_done",  32'(done), 32'd0);
        chk("rl_ready", 32'(bus.in_ready), 32'd1);
        send(8'h00);
        reload = 1'b1;
        send(8'h00);
        reload = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        chk("rl_hold_csum", 32'(cpu_hold), 32'd1);
        send(8'h00);
`endif
        chk("rl_done_after", 32'(done), 32'd1);
        read_chk("rl_old_word", 16'd0, 16'h1234);
        read_chk("rl_old_word1", 16'd1, 16'hABCD);

        // Reset after five bytes, then full resend.
        pulse_reload();
        for (int i = 0; i < 5; i++) begin
            send(prog[i]);
            chk("mid_hold", 32'(cpu_hold), 32'd1);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_hold",  32'(cpu_hold), 32'd1);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_done",  32'(done), 32'd0);
        load_prog(1'b0);
        check_prog("b");

        // Exactly full depth (256 words) is a legal length.
        pulse_reload();
        send(8'h01);
        send(8'h00);
        chk("full_len_err",   32'(err), 32'd0);
        chk("full_len_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;

        // 257 words overflows: error right after the low length byte.
        send(8'h01);
        chk("ovf_not_yet", 32'(err), 32'd0);
        send(8'h01);
        chk("ovf_err",   32'(err), 32'd1);
        chk("ovf_ready", 32'(bus.in_ready), 32'd0);
        chk("ovf_hold",  32'(cpu_hold), 32'd1);
        read_chk("ovf_dout", 16'd0, 16'h0000);
        pulse_reload();
        chk("ovf_reload_err", 32'(err), 32'd0);
        send(8'h00);
        send(8'h00);
`ifdef IMEM_LOADER_CSUM_EN
        send(8'h00);
`endif
        chk("ovf_nowrite_done", 32'(done), 32'd1);
        read_chk("ovf_nowrite_a0", 16'd0, 16'h1234);
        read_chk("ovf_nowrite_a2", 16'd2, 16'h0001);

`ifdef IMEM_LOADER_CSUM_EN
        // Wrong checksum byte.
        pulse_reload();
        for (int i = 0; i < 8; i++) send(prog[i]);
        send(8'hC0);
        chk("csum_err",   32'(err), 32'd1);
        chk("csum_ready", 32'(bus.in_ready), 32'd0);
        chk("csum_hold",  32'(cpu_hold), 32'd1);
        read_chk("csum_dout0", 16'd0, 16'h0000);
        read_chk("csum_dout1", 16'd1, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
